// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared types, constants and helpers for the 8-way round-robin arbiter
package rr_arbiter8_pkg;

    localparam int ARB_MAX_HOLD_DEF = 16;
    localparam int ARB_CNT_W_DEF    = 5;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic logic or8_way(input logic [7:0] v);
        return v[0] | v[1] | v[2] | v[3] | v[4] | v[5] | v[6] | v[7];
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);

    logic [7:0] rot;
    logic [2:0] off;

    // rot[0] is the requester at ptr, so the lowest set bit of rot is the winner's offset
    always_comb begin
        rot = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rot[i] = req[3'(ptr + 3'(i))];
        end
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
        idx = ptr + off;
    end

    assign any = or8_way(req);

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter granting one of 8 requesters with hold timeout
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = ARB_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    arb_state_e       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       grant_idx_q, grant_idx_d;
    logic             timeout_q, timeout_d;

    logic             pick_any;
    logic [2:0]       pick_idx;
    logic             hold_hit;
    logic             abandoned;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign hold_hit  = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign abandoned = ~req[grant_idx_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        timeout_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d     = 8'b1 << pick_idx;
                    grant_idx_d = pick_idx;
                    hold_cnt_d  = CNT_W'(1);
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (done || abandoned || hold_hit) begin
                    // releasing always passes through IDLE, so the holder moves to lowest priority
                    grant_d    = 8'd0;
                    ptr_d      = grant_idx_q + 3'd1;
                    hold_cnt_d = '0;
                    timeout_d  = hold_hit & ~done;
                    state_d    = ARB_IDLE;
                end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            grant_q     <= 8'd0;
            grant_idx_q <= 3'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == ARB_BUSY);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_bad;

    rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".busy"},  32'(busy),  32'h0);
    endtask

    task automatic chk_grant(input string tag, input int idx);
        logic [7:0] oh;
        oh = 8'b1 << idx;
        chk({tag, ".grant"}, 32'(grant),     32'(oh));
        chk({tag, ".idx"},   32'(grant_idx), 32'(idx));
        chk({tag, ".busy"},  32'(busy),      32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;

        // 1: reset with all requesting, before any clock edge
        #3;
        chk("rst.grant",   32'(grant),   32'h0);
        chk("rst.busy",    32'(busy),    32'h0);
        chk("rst.timeout", 32'(timeout), 32'h0);
        step();
        chk("rst_clk.grant", 32'(grant), 32'h0);
        req   = 8'h00;
        rst_n = 1'b1;
        step();
        chk_idle("post_rst");

        // 2: single request, one-cycle latency, done release, ptr moves to 5
        req = 8'h10;
        step();
        chk_grant("single", 4);
        done = 1'b1;
        step();
        chk_idle("single_rel");
        chk("single_rel.timeout", 32'(timeout), 32'h0);
        done = 1'b0;
        req  = 8'h00;
        step();
        done = 1'b1;                     // done while idle is ignored
        step();
        chk_idle("idle_done");
        done = 1'b0;
        req  = 8'h21;                    // ptr=5 picks 5 over 0
        step();
        chk_grant("ptr5", 5);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // 3: all requesting, strict rotation with one idle cycle between grants
        do_reset();
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            chk_grant($sformatf("rot%0d", k), k % 8);
            done = 1'b1;
            step();
            chk_idle($sformatf("rot%0d_gap", k));
            done = 1'b0;
            step();
        end
        req = 8'h00;
        step();
        chk_idle("rot_end");

        // 4: hold timeout after 16 busy cycles (ptr=2 here, req=01 still picks 0)
        req = 8'h01;
        step();
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("hold%0d.busy", c), 32'(busy), 32'h1);
            chk($sformatf("hold%0d.to", c),   32'(timeout), 32'h0);
            if (c < 16) step();
        end
        step();
        chk_idle("to_rel");
        chk("to_rel.timeout", 32'(timeout), 32'h1);
        req = 8'h00;
        step();
        chk("to_after.timeout", 32'(timeout), 32'h0);
        chk_idle("to_after");

        // 4b: done in the same cycle as the hold limit suppresses timeout
        req = 8'h01;
        step();
        chk_grant("to2", 0);
        for (int c = 2; c <= 16; c++) step();
        chk("to2_16.busy", 32'(busy), 32'h1);
        done = 1'b1;
        step();
        chk_idle("to2_rel");
        chk("to2_rel.timeout", 32'(timeout), 32'h0);
        done = 1'b0;
        req  = 8'h00;
        step();

        // 5: holder abandons its request, next grant goes to 3 (ptr=1 picks 2 first)
        req = 8'h0C;
        step();
        chk_grant("aband", 2);
        req = 8'h08;
        step();
        chk_idle("aband_rel");
        chk("aband_rel.timeout", 32'(timeout), 32'h0);
        step();
        chk_grant("aband_next", 3);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;

        // 6: async reset mid-grant; ptr=4 picks 7, after reset ptr=0 picks 0
        req = 8'h81;
        step();
        chk_grant("mid", 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.grant",   32'(grant),   32'h0);
        chk("mid_rst.busy",    32'(busy),    32'h0);
        chk("mid_rst.timeout", 32'(timeout), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk_grant("post_mid", 0);
        chk("post_mid.timeout", 32'(timeout), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
